// File: rtl/stopwatch_ctrl_pkg.sv
// rtl/stopwatch_ctrl_pkg.sv - shared state encoding and defaults for the stopwatch controller
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    // 0.1 s at a 50 MHz system clock
    localparam int TICK_DIV_DFLT = 5000000;

endpackage

// File: rtl/stopwatch_prescaler.sv
// rtl/stopwatch_prescaler.sv - tick prescaler: counts while enabled, holds otherwise, pulses on terminal count
module stopwatch_prescaler
    import stopwatch_ctrl_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DFLT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] cnt_q;
    logic          at_tc;

    assign at_tc = (cnt_q == PW'(TICK_DIV - 1));

    // clr dominates so a clear in the terminal cycle also swallows the tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (en) begin
            cnt_q <= at_tc ? '0 : cnt_q + PW'(1);
            tick  <= at_tc;
        end else begin
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/clear sequencing, tick enable and lap store pointers for the stopwatch
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter  int TICK_DIV = TICK_DIV_DFLT,
    parameter  int DEPTH    = 4,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int CNT_W    = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reset_push,
    input  logic              start_push,
    input  logic              lap_push,
    input  logic              show_push,
    output logic              run,
    output logic              tick,
    output logic              cnt_clr,
    output logic              lap_we,
    output logic [ADDR_W-1:0] lap_waddr,
    output logic              lap_clr,
    output logic [ADDR_W-1:0] lap_raddr,
    output logic [CNT_W-1:0]  lap_cnt,
    output logic              lap_full,
    output logic              lap_ovf
);

    sw_state_t         state_q, state_d;
    logic [CNT_W-1:0]  lap_cnt_d;
    logic [ADDR_W-1:0] lap_raddr_d;
    logic [ADDR_W-1:0] lap_waddr_d;
    logic              lap_we_d;
    logic              lap_clr_d;
    logic              cnt_clr_d;
    logic              lap_ovf_d;
    logic              psc_clr;

    assign psc_clr = reset_push || (start_push && state_q == ST_IDLE);

    stopwatch_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_RUN),
        .clr   (psc_clr),
        .tick  (tick)
    );

    // All pulses are judged against pre-cycle state, lap_cnt and lap_raddr
    always_comb begin
        state_d     = state_q;
        lap_cnt_d   = lap_cnt;
        lap_raddr_d = lap_raddr;
        lap_waddr_d = lap_waddr;
        lap_we_d    = 1'b0;
        lap_clr_d   = 1'b0;
        cnt_clr_d   = 1'b0;
        lap_ovf_d   = 1'b0;

        if (reset_push) begin
            state_d     = ST_IDLE;
            cnt_clr_d   = 1'b1;
            lap_clr_d   = 1'b1;
            lap_cnt_d   = '0;
            lap_raddr_d = '0;
        end else begin
            if (start_push) begin
                case (state_q)
                    ST_IDLE:  state_d = ST_RUN;
                    ST_RUN:   state_d = ST_PAUSE;
                    ST_PAUSE: state_d = ST_RUN;
                    default:  state_d = ST_IDLE;
                endcase
            end

            if (show_push) begin
                if (lap_cnt == '0 || {1'b0, lap_raddr} == lap_cnt - CNT_W'(1))
                    lap_raddr_d = '0;
                else
                    lap_raddr_d = lap_raddr + ADDR_W'(1);
            end

            // Outside RUN the lap key doubles as "clear all laps"
            if (lap_push) begin
                if (state_q == ST_RUN) begin
                    if (lap_cnt < CNT_W'(DEPTH)) begin
                        lap_we_d    = 1'b1;
                        lap_waddr_d = lap_cnt[ADDR_W-1:0];
                        lap_cnt_d   = lap_cnt + CNT_W'(1);
                    end else begin
                        lap_ovf_d   = 1'b1;
                    end
                end else begin
                    lap_clr_d   = 1'b1;
                    lap_cnt_d   = '0;
                    lap_raddr_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            run       <= 1'b0;
            cnt_clr   <= 1'b0;
            lap_we    <= 1'b0;
            lap_waddr <= '0;
            lap_clr   <= 1'b0;
            lap_raddr <= '0;
            lap_cnt   <= '0;
            lap_full  <= 1'b0;
            lap_ovf   <= 1'b0;
        end else begin
            state_q   <= state_d;
            run       <= (state_d == ST_RUN);
            cnt_clr   <= cnt_clr_d;
            lap_we    <= lap_we_d;
            lap_waddr <= lap_waddr_d;
            lap_clr   <= lap_clr_d;
            lap_raddr <= lap_raddr_d;
            lap_cnt   <= lap_cnt_d;
            lap_full  <= (lap_cnt_d == CNT_W'(DEPTH));
            lap_ovf   <= lap_ovf_d;
        end
    end

endmodule
